// File: rtl/tff_toggle_arbiter.sv
// Purpose : shares one T flip-flop between NREQ requesters; one toggle per round-robin grant, then GAP cool-down cycles.
// Latency : req sampled in IDLE at edge k -> gnt/t high in cycle k+1 -> new q visible from edge k+2.
// Backpressure: none held; req is level-sensitive and only looked at in IDLE, so a requester just keeps req high until served.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   req         level request per requester (bit i = requester i)
//   gnt         one-hot grant, high for exactly one cycle
//   t           T input of the shared flop, equal to |gnt
//   q           shared flop state
//   toggle_cnt  total toggles issued, wraps silently
//   busy        high whenever the sequencer is not in IDLE
module tff_toggle_arbiter #(
    parameter int NREQ = 4,
    parameter int GAP  = 2,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            t,
    output logic            q,
    output logic [CNTW-1:0] toggle_cnt,
    output logic            busy
);

    localparam int PW = $clog2(NREQ);
    localparam logic [PW:0]   NREQ_W    = (PW+1)'(NREQ);
    localparam logic [PW-1:0] LAST      = PW'(NREQ - 1);
    // Counter is loaded on the GRANT cycle and counts down to zero in COOL,
    // giving exactly GAP cycles of COOL.
    localparam logic [3:0]    COOL_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        COOL  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic [3:0]      cool_cnt;

    logic            win_vld;
    logic [PW-1:0]   win;
    logic [NREQ-1:0] win_oh;
    logic [PW:0]     sum;
    logic [PW-1:0]   idx;

    // Round-robin search: first set req bit at or after ptr, wrapping mod NREQ.
    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        win_oh  = '0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= NREQ_W) begin
                sum = sum - NREQ_W;
            end
            idx = sum[PW-1:0];
            if (!win_vld && req[idx]) begin
                win_vld     = 1'b1;
                win         = idx;
                win_oh[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_nxt = (win == LAST) ? '0 : win + 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                state_nxt = (GAP == 0) ? IDLE : COOL;
            end
            COOL: begin
                if (cool_cnt == 4'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state != IDLE);
    end

    // Registered grant, pointer, counter and the shared T flop. The grant is
    // loaded on the same edge that moves IDLE -> GRANT, so gnt/t are high for
    // exactly the GRANT cycle and q flips on the edge that ends it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt        <= '0;
            t          <= 1'b0;
            q          <= 1'b0;
            ptr        <= '0;
            toggle_cnt <= '0;
            cool_cnt   <= 4'd0;
        end else begin
            if (state == IDLE && win_vld) begin
                gnt        <= win_oh;
                t          <= 1'b1;
                ptr        <= ptr_nxt;
                toggle_cnt <= toggle_cnt + 1'b1;
            end else begin
                gnt <= '0;
                t   <= 1'b0;
            end

            q <= q ^ t;

            if (state == GRANT) begin
                cool_cnt <= COOL_LOAD;
            end else if (state == COOL && cool_cnt != 4'd0) begin
                cool_cnt <= cool_cnt - 1'b1;
            end
        end
    end

endmodule
